// File: rtl/alu_writeback.sv
// alu_writeback: sequences ALU results into the register-file write port.
// A start captures the ALU outputs; the low result is written in WLO, long
// multiplies (SMUL 0110 / UMUL 0101) also write the high result in WHI,
// and done pulses for one cycle in DONE.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   start               one-cycle capture request (ignored while busy)
//   ALUControl          opcode of the captured result
//   Result, ResultHi    ALU low / high results
//   ALUFlags            ALU flags {N,Z,C,V}
//   RdLo, RdHi          destination registers for Result / ResultHi
//   RegWrite, FlagWrite write enables for this operation
//   busy, done          status (busy in WLO/WHI, done in DONE)
//   WE3, A3, WD3        register-file write port
//   Flags               architectural NZCV register
//
// Optional feature: define WB_FLAGS_EN to include the Flags register;
// without it Flags is tied to zero and ALUFlags/FlagWrite are ignored.
module alu_writeback #(
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [3:0]            ALUControl,
  input  logic [DATA_W-1:0]     Result,
  input  logic [DATA_W-1:0]     ResultHi,
  input  logic [3:0]            ALUFlags,
  input  logic [REG_ADDR_W-1:0] RdLo,
  input  logic [REG_ADDR_W-1:0] RdHi,
  input  logic                  RegWrite,
  input  logic                  FlagWrite,
  output logic                  busy,
  output logic                  done,
  output logic                  WE3,
  output logic [REG_ADDR_W-1:0] A3,
  output logic [DATA_W-1:0]     WD3,
  output logic [3:0]            Flags
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WLO  = 2'd1,
    WHI  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                state;
  logic [3:0]            alu_control_q;
  logic [DATA_W-1:0]     result_q;
  logic [DATA_W-1:0]     result_hi_q;
  logic [REG_ADDR_W-1:0] rd_lo_q;
  logic [REG_ADDR_W-1:0] rd_hi_q;
  logic                  reg_write_q;
  logic                  is_long_q;

`ifdef WB_FLAGS_EN
  logic [3:0] alu_flags_q;
  logic       flag_write_q;
  logic [3:0] flags_q;
`endif

  assign is_long_q = (alu_control_q == 4'b0110) || (alu_control_q == 4'b0101);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      alu_control_q <= '0;
      result_q      <= '0;
      result_hi_q   <= '0;
      rd_lo_q       <= '0;
      rd_hi_q       <= '0;
      reg_write_q   <= 1'b0;
`ifdef WB_FLAGS_EN
      alu_flags_q   <= '0;
      flag_write_q  <= 1'b0;
      flags_q       <= '0;
`endif
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            alu_control_q <= ALUControl;
            result_q      <= Result;
            result_hi_q   <= ResultHi;
            rd_lo_q       <= RdLo;
            rd_hi_q       <= RdHi;
            reg_write_q   <= RegWrite;
`ifdef WB_FLAGS_EN
            alu_flags_q   <= ALUFlags;
            flag_write_q  <= FlagWrite;
`endif
            state <= WLO;
            busy  <= 1'b1;
            done  <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        WLO: begin
`ifdef WB_FLAGS_EN
          if (flag_write_q) flags_q <= alu_flags_q;
`endif
          if (is_long_q) begin
            state <= WHI;
            busy  <= 1'b1;
            done  <= 1'b0;
          end else begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        WHI: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Write port decoded from state and captured registers only.
  always_comb begin
    WE3 = 1'b0;
    A3  = '0;
    WD3 = '0;
    unique case (state)
      WLO: begin
        WE3 = reg_write_q;
        A3  = rd_lo_q;
        WD3 = result_q;
      end
      WHI: begin
        WE3 = reg_write_q;
        A3  = rd_hi_q;
        WD3 = result_hi_q;
      end
      default: begin
        WE3 = 1'b0;
        A3  = '0;
        WD3 = '0;
      end
    endcase
  end

`ifdef WB_FLAGS_EN
  assign Flags = flags_q;
`else
  logic unused_flag_inputs;
  assign unused_flag_inputs = ^{ALUFlags, FlagWrite};
  assign Flags = '0;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: directed scenarios plus randomized traffic,
// all checked against a transaction-level schedule of expected outputs.
module tb_alu_writeback;

  localparam int NC = 1600;

  logic        clk = 1'b0;
  logic        reset, start, RegWrite, FlagWrite;
  logic [3:0]  ALUControl, ALUFlags, RdLo, RdHi;
  logic [31:0] Result, ResultHi;
  logic        busy, done, WE3;
  logic [3:0]  A3, Flags;
  logic [31:0] WD3;

  alu_writeback #(.REG_ADDR_W(4), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .ALUControl(ALUControl),
    .Result(Result), .ResultHi(ResultHi), .ALUFlags(ALUFlags),
    .RdLo(RdLo), .RdHi(RdHi), .RegWrite(RegWrite), .FlagWrite(FlagWrite),
    .busy(busy), .done(done), .WE3(WE3), .A3(A3), .WD3(WD3), .Flags(Flags)
  );

  always #5 clk = ~clk;

  // Expected outputs per cycle (cycle k = period after rising edge k).
  logic        exp_busy  [NC+4];
  logic        exp_done  [NC+4];
  logic        exp_we    [NC+4];
  logic [3:0]  exp_a3    [NC+4];
  logic [31:0] exp_wd    [NC+4];
  logic [3:0]  exp_flags [NC+4];

  int cyc     = 0;
  int free_at = NC + 4;   // first cycle in which a start can be accepted
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Apply inputs for the next edge, schedule its expected effect, advance
  // one cycle and compare every output.
  task automatic step(input logic rst, input logic st, input logic [3:0] op,
                      input logic [31:0] res, input logic [31:0] reshi,
                      input logic [3:0] fl, input logic [3:0] rdlo,
                      input logic [3:0] rdhi, input logic rw, input logic fw);
    int e;
    int d;
    e = cyc + 1;
    reset = rst; start = st; ALUControl = op; Result = res; ResultHi = reshi;
    ALUFlags = fl; RdLo = rdlo; RdHi = rdhi; RegWrite = rw; FlagWrite = fw;
    if (rst) begin
      for (int i = e; i < NC + 4; i++) begin
        exp_busy[i] = 1'b0; exp_done[i] = 1'b0; exp_we[i] = 1'b0;
        exp_a3[i] = '0; exp_wd[i] = '0; exp_flags[i] = '0;
      end
      free_at = e;
    end else if (st && cyc >= free_at) begin
      exp_busy[e] = 1'b1; exp_we[e] = rw; exp_a3[e] = rdlo; exp_wd[e] = res;
      if (op == 4'b0110 || op == 4'b0101) begin
        exp_busy[e+1] = 1'b1; exp_we[e+1] = rw; exp_a3[e+1] = rdhi; exp_wd[e+1] = reshi;
        d = e + 2;
      end else begin
        d = e + 1;
      end
      exp_done[d] = 1'b1;
      free_at = d;
`ifdef WB_FLAGS_EN
      if (fw)
        for (int i = e + 1; i < NC + 4; i++) exp_flags[i] = fl;
`endif
    end
    @(posedge clk);
    cyc = e;
    #1;
    check("busy", {31'b0, busy}, {31'b0, exp_busy[cyc]});
    check("done", {31'b0, done}, {31'b0, exp_done[cyc]});
    check("WE3", {31'b0, WE3}, {31'b0, exp_we[cyc]});
    check("A3", {28'b0, A3}, {28'b0, exp_a3[cyc]});
    check("WD3", WD3, exp_wd[cyc]);
    check("Flags", {28'b0, Flags}, {28'b0, exp_flags[cyc]});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 4'($urandom), $urandom, $urandom, 4'($urandom),
           4'($urandom), 4'($urandom), 1'b1, 1'b1);
  endtask

  logic [3:0] flags_after;

  initial begin
    for (int i = 0; i < NC + 4; i++) begin
      exp_busy[i] = 1'b0; exp_done[i] = 1'b0; exp_we[i] = 1'b0;
      exp_a3[i] = '0; exp_wd[i] = '0; exp_flags[i] = '0;
    end

    // Reset state.
    step(1'b1, 1'b1, 4'b0110, 32'h1234_5678, 32'h9abc_def0, 4'hf, 4'd7, 4'd8, 1'b1, 1'b1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_we", {31'b0, WE3}, 32'd0);
    check("rst_flags", {28'b0, Flags}, 32'd0);
    idle(2);

    // Short write.
    step(1'b0, 1'b1, 4'b0000, 32'h0000_0005, 32'hdead_beef, 4'h0, 4'd3, 4'd9, 1'b1, 1'b0);
    check("short_we", {31'b0, WE3}, 32'd1);
    check("short_a3", {28'b0, A3}, 32'd3);
    check("short_wd", WD3, 32'h0000_0005);
    idle(1);
    check("short_done", {31'b0, done}, 32'd1);
    idle(2);

    // Long multiply.
    step(1'b0, 1'b1, 4'b0110, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 4'h0, 4'd1, 4'd2, 1'b1, 1'b0);
    check("long_lo_a3", {28'b0, A3}, 32'd1);
    check("long_lo_wd", WD3, 32'hFFFF_FFFE);
    idle(1);
    check("long_hi_a3", {28'b0, A3}, 32'd2);
    check("long_hi_wd", WD3, 32'hFFFF_FFFF);
    idle(1);
    check("long_done", {31'b0, done}, 32'd1);
    idle(2);

    // Start held high across operations, including through WHI.
    step(1'b0, 1'b1, 4'b0010, 32'h11, 32'h0, 4'h0, 4'd4, 4'd0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 4'b0101, 32'h22, 32'h33, 4'h0, 4'd5, 4'd6, 1'b1, 1'b0);
    step(1'b0, 1'b1, 4'b0101, 32'h44, 32'h55, 4'h0, 4'd7, 4'd8, 1'b1, 1'b0);
    check("b2b_lo_wd", WD3, 32'h44);
    step(1'b0, 1'b1, 4'b0000, 32'h66, 32'h77, 4'h0, 4'd9, 4'd10, 1'b1, 1'b0);
    check("whi_ignore_wd", WD3, 32'h55);
    step(1'b0, 1'b1, 4'b0000, 32'h88, 32'h99, 4'h0, 4'd11, 4'd12, 1'b1, 1'b0);
    check("b2b_done", {31'b0, done}, 32'd1);
    idle(3);

    // Long multiply with RdLo == RdHi and with RegWrite = 0.
    step(1'b0, 1'b1, 4'b0110, 32'haaaa, 32'hbbbb, 4'h0, 4'd5, 4'd5, 1'b1, 1'b0);
    idle(3);
    step(1'b0, 1'b1, 4'b0101, 32'hcccc, 32'hdddd, 4'h0, 4'd5, 4'd6, 1'b0, 1'b0);
    idle(3);

    // Reset during WLO of UMUL: no WHI write, no done.
    step(1'b0, 1'b1, 4'b0101, 32'h1, 32'h2, 4'h0, 4'd1, 4'd2, 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'b0101, 32'h1, 32'h2, 4'h0, 4'd1, 4'd2, 1'b1, 1'b0);
    check("abort_we", {31'b0, WE3}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    idle(1);
    check("abort_done", {31'b0, done}, 32'd0);
    idle(2);

    // Flags update then hold.
`ifdef WB_FLAGS_EN
    flags_after = 4'b0100;
`else
    flags_after = 4'b0000;
`endif
    step(1'b0, 1'b1, 4'b0100, 32'h5, 32'h0, 4'b0100, 4'd1, 4'd0, 1'b1, 1'b1);
    idle(1);
    check("flags_load", {28'b0, Flags}, {28'b0, flags_after});
    idle(1);
    step(1'b0, 1'b1, 4'b0100, 32'h6, 32'h0, 4'b1011, 4'd1, 4'd0, 1'b1, 1'b0);
    idle(2);
    check("flags_hold", {28'b0, Flags}, {28'b0, flags_after});

    // Randomized traffic.
    for (int n = 0; n < 1200; n++) begin
      int unsigned pick;
      logic [3:0] op;
      pick = $urandom_range(0, 3);
      op = (pick == 0) ? 4'b0110 : (pick == 1) ? 4'b0101 : 4'($urandom_range(0, 15));
      step($urandom_range(0, 39) == 0, 1'($urandom), op, $urandom, $urandom,
           4'($urandom), 4'($urandom), 4'($urandom),
           $urandom_range(0, 3) != 0, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
